// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
//   Shares one AHB-Lite bus between master 0 (CPU) and master 1 (DMA/debug).
//   Address-phase and data-phase ownership are tracked separately so the old
//   owner's last data phase overlaps the new owner's first address phase.
//   A losing master is stalled through its private HREADY_Mx; bursts
//   (owner showing SEQ/BUSY) are never split.
//
// Parameters: AW address width, DW data width.
// Ports:
//   HCLK, HRESETn                     clock, async active-low reset
//   H*_M0 / H*_M1 (in)                per-master address phase + write data
//   HREADY_M0/M1, HRDATA_M0/M1 (out)  per-master ready and read data
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA  muxed bus toward the interconnect
//   HREADY, HRDATA (in)               interconnect response
//   HMASTER (out)                     current address-phase owner
//
// Build option: define AHB_ARB_RR_EN for round-robin on contention;
// otherwise master 0 has fixed priority.

module ahb_master_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [1:0]    HTRANS_M0,
    input  logic          HWRITE_M0,
    input  logic [2:0]    HSIZE_M0,
    input  logic [DW-1:0] HWDATA_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [DW-1:0] HWDATA_M1,
    output logic          HREADY_M0,
    output logic          HREADY_M1,
    output logic [DW-1:0] HRDATA_M0,
    output logic [DW-1:0] HRDATA_M1,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic [DW-1:0] HRDATA,
    output logic          HMASTER
);

    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
    } addr_ph_t;

    addr_ph_t      m_ph   [2];
    logic [DW-1:0] m_wdata[2];
    logic [1:0]    req;
    addr_ph_t      bus_ph;

    logic addr_own, data_own, data_vld;
    logic nxt_own, hold, ctn_win;

    assign m_ph[0]    = {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0};
    assign m_ph[1]    = {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1};
    assign m_wdata[0] = HWDATA_M0;
    assign m_wdata[1] = HWDATA_M1;
    assign req        = {HTRANS_M1[1], HTRANS_M0[1]};

    assign bus_ph  = m_ph[addr_own];
    assign HADDR   = bus_ph.addr;
    assign HTRANS  = bus_ph.trans;
    assign HWRITE  = bus_ph.write;
    assign HSIZE   = bus_ph.size;
    assign HWDATA  = m_wdata[data_own];
    assign HMASTER = addr_own;

    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

    // A master sees the real HREADY while it owns either phase; otherwise it
    // is stalled only if it is trying to start a transfer.
    assign HREADY_M0 = (!addr_own || (data_vld && !data_own)) ? HREADY : !req[0];
    assign HREADY_M1 = ( addr_own || (data_vld &&  data_own)) ? HREADY : !req[1];

    // Owner mid-burst keeps the bus.
    assign hold = (bus_ph.trans == TR_SEQ) || (bus_ph.trans == TR_BUSY);

`ifdef AHB_ARB_RR_EN
    logic last_gnt;

    assign ctn_win = !last_gnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            last_gnt <= 1'b1;
        else if (HREADY && !hold && (&req))
            last_gnt <= ctn_win;
    end
`else
    assign ctn_win = 1'b0;
`endif

    always_comb begin
        nxt_own = addr_own;
        if (!hold) begin
            case (req)
                2'b01:   nxt_own = 1'b0;
                2'b10:   nxt_own = 1'b1;
                2'b11:   nxt_own = ctn_win;
                default: nxt_own = addr_own;   // nobody asks: park
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_own <= 1'b0;
            data_own <= 1'b0;
            data_vld <= 1'b0;
        end else if (HREADY) begin
            addr_own <= nxt_own;
            data_own <= addr_own;
            data_vld <= bus_ph.trans[1];
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed cycle table, contention and
// reset-mid-burst sequences, then random traffic against a reference model.
module tb_ahb_master_arbiter;

    localparam logic [1:0]  ID = 2'd0, NS = 2'd2, SQ = 2'd3;
    localparam logic [31:0] WD0 = 32'h0D0D_0D0D, WD1 = 32'hA5A5_A5A5;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic        HREADY_M0, HREADY_M1;
    logic [31:0] HRDATA_M0, HRDATA_M1, HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HMASTER;
    logic [2:0]  HSIZE;

    int n_cmp = 0, n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(.AW(32), .DW(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1),
        .HREADY_M0(HREADY_M0), .HREADY_M1(HREADY_M1),
        .HRDATA_M0(HRDATA_M0), .HRDATA_M1(HRDATA_M1),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HMASTER(HMASTER)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic [1:0]  t0, t1;
        logic [31:0] a0, a1;
        logic        rdy;
        logic [31:0] rd;
        logic        hm, r0, r1;
        logic [31:0] haddr, hwdata;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [1:0] t0, input logic [31:0] a0,
                       input logic [1:0] t1, input logic [31:0] a1,
                       input logic rdy, input logic [31:0] rd,
                       input logic hm, input logic r0, input logic r1,
                       input logic [31:0] haddr, input logic [31:0] hwdata);
        vec_t v;
        v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.rdy = rdy; v.rd = rd;
        v.hm = hm; v.r0 = r0; v.r1 = r1; v.haddr = haddr; v.hwdata = hwdata;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        HTRANS_M0 = ID; HTRANS_M1 = ID;
        HADDR_M0 = '0; HADDR_M1 = '0;
        HWRITE_M0 = 1'b0; HWRITE_M1 = 1'b1;
        HSIZE_M0 = 3'd2; HSIZE_M1 = 3'd2;
        HWDATA_M0 = WD0; HWDATA_M1 = WD1;
        HREADY = 1'b1; HRDATA = '0;
    endtask

    // Returns #1 after a rising edge, with state at reset values.
    task automatic do_reset();
        HRESETn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    // owner of the bus, owner of the previous bus cycle and whether that cycle
    // carried a transfer, plus number of contended grants taken so far.
    int m_own, m_prev, m_ncont;
    bit m_prev_act;

    task automatic m_reset();
        m_own = 0; m_prev = 0; m_prev_act = 0; m_ncont = 0;
    endtask

    function automatic logic [191:0] m_expect();
        logic [1:0]  tr[2];
        logic [31:0] ad[2], wd[2];
        logic        wr[2], rdy[2];
        logic [2:0]  sz[2];
        tr[0] = HTRANS_M0; tr[1] = HTRANS_M1;
        ad[0] = HADDR_M0;  ad[1] = HADDR_M1;
        wd[0] = HWDATA_M0; wd[1] = HWDATA_M1;
        wr[0] = HWRITE_M0; wr[1] = HWRITE_M1;
        sz[0] = HSIZE_M0;  sz[1] = HSIZE_M1;
        for (int x = 0; x < 2; x++)
            rdy[x] = (x == m_own || (m_prev_act && x == m_prev)) ? HREADY : !tr[x][1];
        return {1'(m_own), rdy[0], rdy[1], ad[m_own], tr[m_own], wr[m_own], sz[m_own],
                wd[m_prev], HRDATA, HRDATA};
    endfunction

    task automatic m_step();
        logic [1:0] tr[2];
        int nxt;
        if (!HREADY) return;
        tr[0] = HTRANS_M0; tr[1] = HTRANS_M1;
        nxt = m_own;
        if (!(tr[m_own] == 2'd1 || tr[m_own] == 2'd3)) begin
            if (tr[0][1] && tr[1][1]) begin
`ifdef AHB_ARB_RR_EN
                nxt = m_ncont % 2;
                m_ncont++;
`else
                nxt = 0;
`endif
            end else if (tr[0][1]) nxt = 0;
            else if (tr[1][1]) nxt = 1;
        end
        m_prev_act = tr[m_own][1];
        m_prev = m_own;
        m_own = nxt;
    endtask

    function automatic logic [191:0] dut_out();
        return {HMASTER, HREADY_M0, HREADY_M1, HADDR, HTRANS, HWRITE, HSIZE,
                HWDATA, HRDATA_M0, HRDATA_M1};
    endfunction

    initial begin
        logic exp_hm[6];

        idle_inputs();
        do_reset();

        // reset state outputs: no traffic, owner 0
        @(negedge HCLK);
        chk("reset_hmaster", 192'(HMASTER), 192'(0));
        chk("reset_rdy", 192'({HREADY_M0, HREADY_M1}), 192'(2'b11));
        chk("reset_hwdata", 192'(HWDATA), 192'(WD0));
        @(posedge HCLK); #1;

        // single master, handover, burst hold, wait states
        add(NS, 32'h2000_0000, ID, 32'h4000_0010, 1, 32'h0,         0, 1, 1, 32'h2000_0000, WD0);
        add(NS, 32'h2000_0004, ID, 32'h4000_0010, 1, 32'h1111_1111, 0, 1, 1, 32'h2000_0004, WD0);
        add(ID, 32'h2000_0004, ID, 32'h4000_0010, 1, 32'h2222_2222, 0, 1, 1, 32'h2000_0004, WD0);
        add(ID, 32'h2000_0004, NS, 32'h4000_0010, 1, 32'h0,         0, 1, 0, 32'h2000_0004, WD0);
        add(ID, 32'h2000_0004, NS, 32'h4000_0010, 1, 32'h0,         1, 1, 1, 32'h4000_0010, WD0);
        add(ID, 32'h2000_0004, ID, 32'h4000_0010, 1, 32'h0,         1, 1, 1, 32'h4000_0010, WD1);
        add(ID, 32'h2000_0004, NS, 32'h4000_0100, 1, 32'h0,         1, 1, 1, 32'h4000_0100, WD1);
        add(NS, 32'h2000_0100, SQ, 32'h4000_0104, 1, 32'h0,         1, 0, 1, 32'h4000_0104, WD1);
        add(NS, 32'h2000_0100, SQ, 32'h4000_0108, 1, 32'h3333_3333, 1, 0, 1, 32'h4000_0108, WD1);
        add(NS, 32'h2000_0100, SQ, 32'h4000_010C, 1, 32'h0,         1, 0, 1, 32'h4000_010C, WD1);
        add(NS, 32'h2000_0100, ID, 32'h4000_010C, 1, 32'h0,         1, 0, 1, 32'h4000_010C, WD1);
        add(NS, 32'h2000_0100, ID, 32'h4000_010C, 1, 32'h0,         0, 1, 1, 32'h2000_0100, WD1);
        add(ID, 32'h2000_0100, NS, 32'h4000_0200, 0, 32'h0,         0, 0, 0, 32'h2000_0100, WD0);
        add(ID, 32'h2000_0100, NS, 32'h4000_0200, 0, 32'h0,         0, 0, 0, 32'h2000_0100, WD0);
        add(ID, 32'h2000_0100, NS, 32'h4000_0200, 0, 32'h0,         0, 0, 0, 32'h2000_0100, WD0);
        add(ID, 32'h2000_0100, NS, 32'h4000_0200, 1, 32'h4444_4444, 0, 1, 0, 32'h2000_0100, WD0);
        add(ID, 32'h2000_0100, NS, 32'h4000_0200, 1, 32'h0,         1, 1, 1, 32'h4000_0200, WD0);
        add(ID, 32'h2000_0100, ID, 32'h4000_0200, 1, 32'h0,         1, 1, 1, 32'h4000_0200, WD1);

        foreach (tbl[i]) begin
            HTRANS_M0 = tbl[i].t0; HADDR_M0 = tbl[i].a0;
            HTRANS_M1 = tbl[i].t1; HADDR_M1 = tbl[i].a1;
            HREADY = tbl[i].rdy;   HRDATA = tbl[i].rd;
            @(negedge HCLK);
            chk($sformatf("tbl%0d_hmaster", i), 192'(HMASTER), 192'(tbl[i].hm));
            chk($sformatf("tbl%0d_rdy", i), 192'({HREADY_M0, HREADY_M1}),
                192'({tbl[i].r0, tbl[i].r1}));
            chk($sformatf("tbl%0d_haddr", i), 192'(HADDR), 192'(tbl[i].haddr));
            chk($sformatf("tbl%0d_hwdata", i), 192'(HWDATA), 192'(tbl[i].hwdata));
            chk($sformatf("tbl%0d_rdata", i), 192'({HRDATA_M0, HRDATA_M1}),
                192'({tbl[i].rd, tbl[i].rd}));
            @(posedge HCLK); #1;
        end

        // contention: both masters stream NONSEQ from reset
`ifdef AHB_ARB_RR_EN
        exp_hm = '{0, 0, 1, 0, 1, 0};
`else
        exp_hm = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        HTRANS_M0 = NS; HADDR_M0 = 32'h2000_0500;
        HTRANS_M1 = NS; HADDR_M1 = 32'h4000_0600;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            chk($sformatf("contend%0d_hmaster", i), 192'(HMASTER), 192'(exp_hm[i]));
            @(posedge HCLK); #1;
        end

        // reset in the middle of an M1 burst
        do_reset();
        HTRANS_M1 = NS; HADDR_M1 = 32'h4000_0300;
        @(negedge HCLK);
        chk("rst_pre_hmaster", 192'(HMASTER), 192'(0));
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("rst_grant_hmaster", 192'(HMASTER), 192'(1));
        @(posedge HCLK); #1;
        HTRANS_M1 = SQ; HADDR_M1 = 32'h4000_0304;
        @(posedge HCLK); #1;
        HTRANS_M1 = SQ; HADDR_M1 = 32'h4000_0308;
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_hmaster", 192'(HMASTER), 192'(0));
        chk("rst_mid_rdy1", 192'(HREADY_M1), 192'(0));
        chk("rst_mid_hwdata", 192'(HWDATA), 192'(WD0));
        HTRANS_M1 = ID;
        HTRANS_M0 = NS; HADDR_M0 = 32'h2000_0400;
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk("rst_post_rdy0", 192'(HREADY_M0), 192'(1));
        chk("rst_post_haddr", 192'(HADDR), 192'(32'h2000_0400));
        @(posedge HCLK); #1;
        HTRANS_M0 = ID;
        @(negedge HCLK);
        chk("rst_post_data", 192'({HMASTER, HREADY_M0}), 192'(2'b01));
        @(posedge HCLK); #1;

        // random traffic against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            HTRANS_M0 = 2'($urandom_range(0, 3));
            HTRANS_M1 = 2'($urandom_range(0, 3));
            HADDR_M0 = $urandom;  HADDR_M1 = $urandom;
            HWDATA_M0 = $urandom; HWDATA_M1 = $urandom;
            HWRITE_M0 = 1'($urandom); HWRITE_M1 = 1'($urandom);
            HSIZE_M0 = 3'($urandom);  HSIZE_M1 = 3'($urandom);
            HREADY = ($urandom_range(0, 3) != 0);
            HRDATA = $urandom;
            @(negedge HCLK);
            chk($sformatf("rand%0d", i), dut_out(), m_expect());
            @(posedge HCLK);
            m_step();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
